// File: rtl/vector_mem_responder_pkg.sv
// Shared widths, host-loader state encoding and the byte-lane merge helper
// for the vector memory responder.
package vector_mem_responder_pkg;

   localparam int unsigned LINE_BYTES = 32;
   localparam int unsigned LINE_W     = 256;
   localparam int unsigned ADDR_W     = 14;
   localparam int unsigned LEN_W      = 8;
   localparam int unsigned BCNT_W     = 5;

   typedef enum logic [1:0] {
      H_IDLE,
      H_COLLECT,
      H_COMMIT
   } host_state_t;

   // Overlay the enabled byte lanes of new_line onto old_line.
   function automatic logic [LINE_W-1:0] merge_line(
      input logic [LINE_W-1:0]     old_line,
      input logic [LINE_W-1:0]     new_line,
      input logic [LINE_BYTES-1:0] be
   );
      logic [LINE_W-1:0] res;
      res = old_line;
      for (int unsigned i = 0; i < LINE_BYTES; i++) begin
         if (be[i]) res[8*i +: 8] = new_line[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/vector_mem_responder_assembler.sv
// Packs accepted host bytes little-endian into one 256-bit line; cleared on
// reset or once the line has been committed.
module byte_line_assembler
   import vector_mem_responder_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              accept,
   input  logic [7:0]        data_byte,
   output logic              last_byte_c,
   output logic              line_full,
   output logic [LINE_W-1:0] line_data
);

   logic [BCNT_W-1:0] byte_cnt;

   assign last_byte_c = accept && !line_full && (byte_cnt == BCNT_W'(LINE_BYTES - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         byte_cnt  <= '0;
         line_full <= 1'b0;
         line_data <= '0;
      end else if (accept && !line_full) begin
         line_data[{byte_cnt, 3'b000} +: 8] <= data_byte;
         byte_cnt                           <= byte_cnt + BCNT_W'(1);
         if (byte_cnt == BCNT_W'(LINE_BYTES - 1)) line_full <= 1'b1;
      end
   end

endmodule

// File: rtl/vector_mem_responder.sv
// Line-wide memory responder: core read/write port with write-first bypass,
// plus a host byte-stream loader that commits whole lines when the core is idle.
module vector_mem_responder
   import vector_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rden,
   input  logic                  wren,
   input  logic [ADDR_W-1:0]     ip_address,
   input  logic [LINE_BYTES-1:0] byteena,
   input  logic [LINE_W-1:0]     writeData,
   output logic [LINE_W-1:0]     readData,
   input  logic                  host_start,
   input  logic [ADDR_W-1:0]     host_addr,
   input  logic [LEN_W-1:0]      host_len,
   input  logic                  host_valid,
   input  logic [7:0]            host_byte,
   output logic                  host_ready,
   output logic                  host_busy,
   output logic                  host_done
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [LINE_W-1:0] mem [DEPTH];

   host_state_t       state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]  lines_left_q, lines_left_d;
   logic              host_ready_d, host_busy_d, host_done_d;

   logic              accept_c, last_byte_c, line_full, commit_c;
   logic [LINE_W-1:0] host_line;

   logic              core_in_range_c, host_in_range_c;
   logic [IDX_W-1:0]  core_idx_c, host_idx_c;
   logic              wr_en_c;
   logic [IDX_W-1:0]  wr_idx_c;
   logic [LINE_BYTES-1:0] wr_be_c;
   logic [LINE_W-1:0] wr_line_c, stored_c, rd_line_c;

   assign accept_c = host_valid && host_ready;
   // Core port owns the array whenever wren is high, even for an empty byteena.
   assign commit_c = (state_q == H_COMMIT) && line_full && !wren;

   byte_line_assembler u_asm (
      .clk         (clk),
      .reset       (reset),
      .clear       (commit_c),
      .accept      (accept_c),
      .data_byte   (host_byte),
      .last_byte_c (last_byte_c),
      .line_full   (line_full),
      .line_data   (host_line)
   );

   assign core_in_range_c = 32'(ip_address) < DEPTH;
   assign host_in_range_c = 32'(cur_addr_q) < DEPTH;
   assign core_idx_c      = ip_address[IDX_W-1:0];
   assign host_idx_c      = cur_addr_q[IDX_W-1:0];

   // Single write port: core first, host commit otherwise.
   always_comb begin
      wr_en_c   = 1'b0;
      wr_idx_c  = core_idx_c;
      wr_be_c   = byteena;
      wr_line_c = writeData;
      if (wren) begin
         wr_en_c = core_in_range_c;
      end else if (commit_c) begin
         wr_en_c   = host_in_range_c;
         wr_idx_c  = host_idx_c;
         wr_be_c   = '1;
         wr_line_c = host_line;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         for (int unsigned i = 0; i < LINE_BYTES; i++) begin
            if (wr_be_c[i]) mem[wr_idx_c][8*i +: 8] <= wr_line_c[8*i +: 8];
         end
      end
   end

   assign stored_c  = mem[core_idx_c];
   assign rd_line_c = (wr_en_c && (wr_idx_c == core_idx_c))
                      ? merge_line(stored_c, wr_line_c, wr_be_c) : stored_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         readData <= '0;
      end else if (rden) begin
         readData <= core_in_range_c ? rd_line_c : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= H_IDLE;
         cur_addr_q   <= '0;
         lines_left_q <= '0;
         host_ready   <= 1'b0;
         host_busy    <= 1'b0;
         host_done    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         lines_left_q <= lines_left_d;
         host_ready   <= host_ready_d;
         host_busy    <= host_busy_d;
         host_done    <= host_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      lines_left_d = lines_left_q;
      host_done_d  = 1'b0;
      case (state_q)
         H_IDLE: begin
            if (host_start) begin
               cur_addr_d   = host_addr;
               lines_left_d = (host_len == '0) ? LEN_W'(1) : host_len;
               state_d      = H_COLLECT;
            end
         end
         H_COLLECT: begin
            if (last_byte_c) state_d = H_COMMIT;
         end
         H_COMMIT: begin
            if (commit_c) begin
               lines_left_d = lines_left_q - LEN_W'(1);
               if (lines_left_q == LEN_W'(1)) begin
                  host_done_d = 1'b1;
                  state_d     = H_IDLE;
               end else begin
                  cur_addr_d = cur_addr_q + ADDR_W'(1);
                  state_d    = H_COLLECT;
               end
            end
         end
         default: state_d = H_IDLE;
      endcase
      host_ready_d = (state_d == H_COLLECT);
      host_busy_d  = (state_d != H_IDLE);
   end

endmodule
